// File: rtl/pipe_step_pkg.sv
// Shared types and constants for the single-step pipeline sequencer.
// Optional display watchdog is enabled with macro PIPE_STEP_TIMEOUT_EN.
package pipe_step_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned TO_W      = 16;

  // Last watchdog count value; REFRESH gives up after 2^TO_W - 1 cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(16'hFFFE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STEP     = 3'd1,
    SETTLE   = 3'd2,
    REFRESH  = 3'd3,
    RUN_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/pipe_step_ctrl_rise_edge.sv
// Registered rising-edge detector: one-cycle pulse per low-to-high input transition.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic level_q, level_d;
  logic pulse_q, pulse_d;

  // Next values: remember the level, flag a new high.
  always_comb begin
    level_d = din;
    pulse_d = din & ~level_q;
  end

  // Edge-detect state flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Single-step / free-run sequencer for the 5-stage pipeline with LCD refresh handshake.
// Define PIPE_STEP_TIMEOUT_EN to add the REFRESH watchdog and the disp_timeout output.
module pipe_step_ctrl
  import pipe_step_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned RUN_PERIOD = 5000000,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             CCLK,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             sw_change,
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
  input  logic             disp_ack,
  output logic             step_en,
  output logic             disp_req,
  output logic [CNT_W-1:0] clk_cnt,
  output logic             running,
`ifdef PIPE_STEP_TIMEOUT_EN
  output logic             disp_timeout,
`endif
  output logic             halted
);

  localparam int unsigned PER_W = (RUN_PERIOD > 2) ? $clog2(RUN_PERIOD) : 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic step_rise, run_rise;

  state_e           state_q, state_d;
  logic             step_en_q, step_en_d;
  logic             disp_req_q, disp_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             pending_q, pending_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [SET_W-1:0] set_q, set_d;
`ifdef PIPE_STEP_TIMEOUT_EN
  logic [TO_W-1:0]  to_q, to_d;
  logic             timeout_q, timeout_d;
`endif

  rise_edge u_step_edge (.clk(CCLK), .rst_n(rst), .din(btn_step), .pulse(step_rise));
  rise_edge u_run_edge  (.clk(CCLK), .rst_n(rst), .din(btn_run),  .pulse(run_rise));

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    step_en_d  = 1'b0;
    disp_req_d = disp_req_q;
    cnt_d      = cnt_q;
    running_d  = running_q;
    halted_d   = halted_q;
    pending_d  = pending_q;
    per_d      = per_q;
    set_d      = set_q;
`ifdef PIPE_STEP_TIMEOUT_EN
    to_d       = to_q;
    timeout_d  = timeout_q;
`endif

    // A single press is remembered while busy; extra presses collapse into it.
    if (step_rise && (state_q != IDLE)) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (run_rise) begin
          running_d = ~running_q;
          if (!running_q) halted_d = 1'b0;
        end
        if (step_rise || pending_q) begin
          state_d   = STEP;
          step_en_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          pending_d = 1'b0;
        end else if (running_d) begin
          state_d = RUN_WAIT;
          per_d   = '0;
        end else if (sw_change) begin
          state_d    = REFRESH;
          disp_req_d = 1'b1;
`ifdef PIPE_STEP_TIMEOUT_EN
          to_d       = '0;
`endif
        end
      end

      STEP: begin
        state_d = SETTLE;
        set_d   = '0;
      end

      SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) begin
          if (running_q && bp_valid && (pc == bp_addr)) begin
            running_d = 1'b0;
            halted_d  = 1'b1;
          end
          state_d    = REFRESH;
          disp_req_d = 1'b1;
`ifdef PIPE_STEP_TIMEOUT_EN
          to_d       = '0;
`endif
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end

      REFRESH: begin
        if (disp_ack) begin
          disp_req_d = 1'b0;
          state_d    = IDLE;
`ifdef PIPE_STEP_TIMEOUT_EN
        end else if (to_q == TO_LAST) begin
          disp_req_d = 1'b0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
`endif
        end
      end

      RUN_WAIT: begin
        if (run_rise) begin
          running_d = 1'b0;
          state_d   = IDLE;
        end else if (per_q == PER_W'(RUN_PERIOD - 2)) begin
          state_d   = STEP;
          step_en_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          per_d     = '0;
        end else begin
          per_d = per_q + PER_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CCLK) begin
    if (!rst) begin
      state_q    <= IDLE;
      step_en_q  <= 1'b0;
      disp_req_q <= 1'b0;
      cnt_q      <= '0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      pending_q  <= 1'b0;
      per_q      <= '0;
      set_q      <= '0;
`ifdef PIPE_STEP_TIMEOUT_EN
      to_q       <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_en_q  <= step_en_d;
      disp_req_q <= disp_req_d;
      cnt_q      <= cnt_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      pending_q  <= pending_d;
      per_q      <= per_d;
      set_q      <= set_d;
`ifdef PIPE_STEP_TIMEOUT_EN
      to_q       <= to_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign step_en  = step_en_q;
  assign disp_req = disp_req_q;
  assign clk_cnt  = cnt_q;
  assign running  = running_q;
  assign halted   = halted_q;
`ifdef PIPE_STEP_TIMEOUT_EN
  assign disp_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Scoreboard bench for pipe_step_ctrl: stimulus predicts refresh events, a monitor checks them.
module tb_pipe_step_ctrl;

  localparam int unsigned CNT_W      = 8;
  localparam int unsigned RUN_PERIOD = 10;
  localparam int unsigned SETTLE_CYC = 4;

  logic             CCLK = 1'b0;
  logic             rst, btn_step, btn_run, sw_change, bp_valid, disp_ack;
  logic [31:0]      pc, bp_addr;
  logic             step_en, disp_req, running, halted;
  logic [CNT_W-1:0] clk_cnt;
`ifdef PIPE_STEP_TIMEOUT_EN
  logic             disp_timeout;
`endif

  always #5 CCLK = ~CCLK;

  pipe_step_ctrl #(.CNT_W(CNT_W), .RUN_PERIOD(RUN_PERIOD), .SETTLE_CYC(SETTLE_CYC)) dut (
    .CCLK(CCLK), .rst(rst), .btn_step(btn_step), .btn_run(btn_run),
    .sw_change(sw_change), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .disp_ack(disp_ack), .step_en(step_en), .disp_req(disp_req),
    .clk_cnt(clk_cnt), .running(running),
`ifdef PIPE_STEP_TIMEOUT_EN
    .disp_timeout(disp_timeout),
`endif
    .halted(halted));

  // One predicted display refresh.
  typedef struct {
    bit stepped;
    int cnt;
    bit run;
    bit halt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, last_step_cyc = -100, steps_seen = 0, steps_exp = 0;
  int   pc_idx = 0;
  int   model_cnt = 0;
  bit   model_run = 0, model_halt = 0;
  bit   ack_en = 1;
  int   ack_dly = 0, ack_wait = 0;
  bit   prev_req = 0, prev_step = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CCLK);
  endtask

  task automatic press_step(input int hold);
    btn_step = 1'b1; tick(hold);
    btn_step = 1'b0; tick(1);
  endtask

  // Predict one manual step: counter advances, mode flags unchanged.
  task automatic push_step();
    model_cnt = (model_cnt + 1) % 256;
    steps_exp++;
    q.push_back('{stepped: 1'b1, cnt: model_cnt, run: model_run, halt: model_halt});
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((q.size() != 0 || disp_req) && b < 3000) begin tick(1); b++; end
    if (b >= 3000) chk("idle_wait_timeout", b, 0);
    tick(3);
  endtask

  task automatic wait_req();
    int b = 0;
    while (!disp_req && b < 200) begin tick(1); b++; end
    if (b >= 200) chk("req_wait_timeout", b, 0);
  endtask

  task automatic op_single(input bit sw_during);
    ack_dly = $urandom_range(0, 4);
    push_step();
    press_step($urandom_range(1, 3));
    if (sw_during) begin sw_change = 1'b1; tick(1); sw_change = 1'b0; end
    wait_idle();
  endtask

  task automatic op_sw();
    ack_dly = $urandom_range(0, 4);
    q.push_back('{stepped: 1'b0, cnt: model_cnt, run: model_run, halt: model_halt});
    sw_change = 1'b1; tick(1); sw_change = 1'b0;
    wait_idle();
  endtask

  task automatic op_pending();
    ack_dly = 12;
    push_step();
    push_step();
    press_step(1);
    wait_req();
    repeat (3) press_step(1);
    wait_idle();
  endtask

  // Free-run until the k-th step, whose fetch PC 4*(k-1) matches the breakpoint.
  task automatic op_run(input int k);
    ack_dly  = $urandom_range(0, 3);
    pc_idx   = 0;
    pc       = 32'd0;
    bp_addr  = 32'(4 * (k - 1));
    bp_valid = 1'b1;
    for (int i = 1; i <= k; i++) begin
      model_cnt = (model_cnt + 1) % 256;
      steps_exp++;
      q.push_back('{stepped: 1'b1, cnt: model_cnt, run: (i < k), halt: (i == k)});
    end
    model_run  = 1'b0;
    model_halt = 1'b1;
    btn_run = 1'b1; tick(1); btn_run = 1'b0; tick(1);
    wait_idle();
    chk("run_dropped", int'(running), 0);
    chk("halted_set", int'(halted), 1);
    bp_valid = 1'b0;
  endtask

  // Display model: acknowledge ack_dly cycles after each request.
  always @(negedge CCLK) begin
    if (disp_ack) begin
      disp_ack = 1'b0;
      ack_wait = 0;
    end else if (disp_req === 1'b1 && ack_en) begin
      if (ack_wait >= ack_dly) begin disp_ack = 1'b1; ack_wait = 0; end
      else ack_wait++;
    end else begin
      ack_wait = 0;
    end
  end

  // Monitor: step strobes drive the PC model; refresh requests are checked against the queue.
  always @(negedge CCLK) begin
    exp_t e;
    cyc++;
    if (step_en === 1'b1) begin
      chk("step_en_single_cycle", int'(prev_step), 0);
      steps_seen++;
      last_step_cyc = cyc;
      pc = 32'(4 * pc_idx);
      pc_idx++;
    end
    if (disp_req === 1'b1 && !prev_req) begin
      if (q.size() == 0) begin
        chk("unexpected_refresh", 1, 0);
      end else begin
        e = q.pop_front();
        chk("refresh_clk_cnt", int'(clk_cnt), e.cnt);
        chk("refresh_running", int'(running), int'(e.run));
        chk("refresh_halted", int'(halted), int'(e.halt));
        if (e.stepped) chk("req_latency", cyc - last_step_cyc, SETTLE_CYC + 1);
      end
    end
    prev_req  = (disp_req === 1'b1);
    prev_step = (step_en === 1'b1);
  end

  initial begin
    int start_cnt;
    rst = 1'b0; btn_step = 1'b0; btn_run = 1'b0; sw_change = 1'b0;
    bp_valid = 1'b0; bp_addr = 32'd0; pc = 32'd0; disp_ack = 1'b0;
    tick(3);
    chk("reset_step_en", int'(step_en), 0);
    chk("reset_disp_req", int'(disp_req), 0);
    chk("reset_clk_cnt", int'(clk_cnt), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_halted", int'(halted), 0);
`ifdef PIPE_STEP_TIMEOUT_EN
    chk("reset_timeout", int'(disp_timeout), 0);
`endif
    rst = 1'b1;
    tick(2);

    // Directed cases.
    ack_dly = 2; push_step(); press_step(2); wait_idle();
    chk("first_step_cnt", int'(clk_cnt), 1);
    op_sw();
    chk("sw_no_step_cnt", int'(clk_cnt), 1);
    op_pending();
    op_run(4);
    chk("bp_run_cnt", int'(clk_cnt), 7);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op_single(1'($urandom_range(0, 1)));
        1: op_sw();
        2: op_pending();
        default: op_run($urandom_range(1, 5));
      endcase
    end

    // Reset while a refresh is outstanding.
    ack_en = 1'b0;
    push_step();
    press_step(1);
    wait_req();
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("midreq_reset_disp_req", int'(disp_req), 0);
    chk("midreq_reset_step_en", int'(step_en), 0);
    chk("midreq_reset_clk_cnt", int'(clk_cnt), 0);
    chk("midreq_reset_running", int'(running), 0);
    chk("midreq_reset_halted", int'(halted), 0);
    rst = 1'b1;
    ack_en = 1'b1;
    model_cnt = 0; model_run = 1'b0; model_halt = 1'b0;
    tick(2);

    // Counter wrap after 256 steps from zero.
    start_cnt = int'(clk_cnt);
    ack_dly = 0;
    for (int i = 0; i < 256; i++) begin
      push_step();
      press_step(1);
      wait_idle();
    end
    chk("wrap_start", start_cnt, 0);
    chk("wrap_cnt", int'(clk_cnt), 0);

`ifdef PIPE_STEP_TIMEOUT_EN
    begin
      int hi = 0;
      ack_en = 1'b0;
      push_step();
      press_step(1);
      wait_req();
      while (disp_req && hi < 70000) begin hi++; tick(1); end
      chk("timeout_req_cycles", hi, 65535);
      chk("timeout_flag", int'(disp_timeout), 1);
      ack_en = 1'b1;
      tick(2);
    end
`endif

    chk("total_steps", steps_seen, steps_exp);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
